// File: rtl/ant_sense_scan.sv
// Neighbour-sensing scan engine: probes a fan of 3 or 5 cells around the ant
// over the grid read handshake and reports the heading of the strongest cell.
module ant_sense_scan #(
   parameter int unsigned X_BITS   = 8,
   parameter int unsigned Y_BITS   = 7,
   parameter int unsigned GRID_W   = 160,
   parameter int unsigned GRID_H   = 120,
   parameter int unsigned VAL_BITS = 8,
   parameter int unsigned FAN      = 3,
   parameter int unsigned WRAP     = 1
) (
   input  logic                Clk,
   input  logic                Reset_n,
   input  logic                start,
   input  logic [X_BITS-1:0]   X,
   input  logic [Y_BITS-1:0]   Y,
   input  logic [2:0]          dir,
   output logic                rd_req,
   output logic [X_BITS-1:0]   rd_X,
   output logic [Y_BITS-1:0]   rd_Y,
   input  logic                rd_ack,
   input  logic [VAL_BITS-1:0] rd_data,
   output logic                busy,
   output logic                done,
   output logic [2:0]          best_dir,
   output logic [VAL_BITS-1:0] best_val,
   output logic                found
);

   localparam int unsigned P_BITS = 3;

   typedef enum logic [1:0] {S_IDLE, S_PROBE, S_DONE} state_t;

   state_t              state_q;
   logic [X_BITS-1:0]   x_q;
   logic [Y_BITS-1:0]   y_q;
   logic [2:0]          dir_q;
   logic [P_BITS-1:0]   p_q;
   logic [2:0]          hd_q;
   logic                rd_req_q;
   logic [X_BITS-1:0]   rd_x_q;
   logic [Y_BITS-1:0]   rd_y_q;
   logic                busy_q;
   logic                done_q;
   logic [2:0]          best_dir_q;
   logic [VAL_BITS-1:0] best_val_q;
   logic                found_q;

   logic [X_BITS-1:0]   src_x;
   logic [Y_BITS-1:0]   src_y;
   logic [2:0]          src_dir;
   logic [P_BITS-1:0]   p_d;
   logic [2:0]          hd_d;
   logic [2:0]          hd_off;
   logic                xinc, xdec, yinc, ydec;
   logic [X_BITS:0]     xw;
   logic [Y_BITS:0]     yw;
   logic                x_oob, y_oob;
   logic [X_BITS-1:0]   nx_d;
   logic [Y_BITS-1:0]   ny_d;
   logic                inb_d;

   // Next probe cell: from the live inputs when starting, else from the latched position.
   always_comb begin
      src_x   = x_q;
      src_y   = y_q;
      src_dir = dir_q;
      p_d     = p_q + P_BITS'(1);
      if (state_q == S_IDLE) begin
         src_x   = X;
         src_y   = Y;
         src_dir = dir;
         p_d     = '0;
      end
      case (p_d)
         P_BITS'(1): hd_off = 3'd7;
         P_BITS'(2): hd_off = 3'd1;
         P_BITS'(3): hd_off = 3'd6;
         P_BITS'(4): hd_off = 3'd2;
         default:    hd_off = 3'd0;
      endcase
      hd_d = src_dir + hd_off;
      xinc = (hd_d == 3'd1) || (hd_d == 3'd2) || (hd_d == 3'd3);
      xdec = (hd_d == 3'd5) || (hd_d == 3'd6) || (hd_d == 3'd7);
      yinc = (hd_d == 3'd3) || (hd_d == 3'd4) || (hd_d == 3'd5);
      ydec = (hd_d == 3'd7) || (hd_d == 3'd0) || (hd_d == 3'd1);
      // One bit wider so that 0-1 lands far above the grid limit.
      xw    = {1'b0, src_x} + (X_BITS+1)'(xinc) - (X_BITS+1)'(xdec);
      yw    = {1'b0, src_y} + (Y_BITS+1)'(yinc) - (Y_BITS+1)'(ydec);
      x_oob = xw >= (X_BITS+1)'(GRID_W);
      y_oob = yw >= (Y_BITS+1)'(GRID_H);
      nx_d  = X_BITS'(xw);
      ny_d  = Y_BITS'(yw);
      inb_d = !(x_oob || y_oob);
      if (WRAP != 0) begin
         inb_d = 1'b1;
         if (xdec && (src_x == '0))   nx_d = X_BITS'(GRID_W - 1);
         else if (xinc && x_oob)      nx_d = '0;
         if (ydec && (src_y == '0))   ny_d = Y_BITS'(GRID_H - 1);
         else if (yinc && y_oob)      ny_d = '0;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q    <= S_IDLE;
         x_q        <= '0;
         y_q        <= '0;
         dir_q      <= '0;
         p_q        <= '0;
         hd_q       <= '0;
         rd_req_q   <= 1'b0;
         rd_x_q     <= '0;
         rd_y_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         best_dir_q <= '0;
         best_val_q <= '0;
         found_q    <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  x_q        <= X;
                  y_q        <= Y;
                  dir_q      <= dir;
                  p_q        <= p_d;
                  hd_q       <= hd_d;
                  rd_req_q   <= inb_d;
                  rd_x_q     <= nx_d;
                  rd_y_q     <= ny_d;
                  best_dir_q <= dir;
                  best_val_q <= '0;
                  found_q    <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= S_PROBE;
               end
            end
            S_PROBE: begin
               // Strictly greater keeps the earlier probe on ties.
               if (rd_req_q && rd_ack && (!found_q || (rd_data > best_val_q))) begin
                  best_val_q <= rd_data;
                  best_dir_q <= hd_q;
                  found_q    <= 1'b1;
               end
               if (!rd_req_q || rd_ack) begin
                  if (p_q == P_BITS'(FAN - 1)) begin
                     rd_req_q <= 1'b0;
                     done_q   <= 1'b1;
                     state_q  <= S_DONE;
                  end else begin
                     p_q      <= p_d;
                     hd_q     <= hd_d;
                     rd_req_q <= inb_d;
                     rd_x_q   <= nx_d;
                     rd_y_q   <= ny_d;
                  end
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign rd_req   = rd_req_q;
   assign rd_X     = rd_x_q;
   assign rd_Y     = rd_y_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign best_dir = best_dir_q;
   assign best_val = best_val_q;
   assign found    = found_q;

endmodule

// File: tb/tb_ant_sense_scan.sv
// Scoreboard bench for ant_sense_scan: three instances (wrap/fan3, clamp/fan3,
// wrap/fan5) share one responder and one negedge scoreboard.
module tb_ant_sense_scan;

   typedef struct { logic [7:0] x; logic [6:0] y; } rd_t;
   typedef struct { logic [2:0] d; logic [7:0] v; logic f; int c; } res_t;

   logic       Clk;
   logic       Reset_n;
   logic       start;
   logic [7:0] X;
   logic [6:0] Y;
   logic [2:0] dir;
   logic       rd_ack_m;
   logic [7:0] rd_data_m;
   logic       ack_force;
   logic [1:0] sel;

   logic       start_w [3];
   logic       ack_w   [3];
   logic       rdreq_w [3];
   logic [7:0] rdx_w   [3];
   logic [6:0] rdy_w   [3];
   logic       busy_w  [3];
   logic       done_w  [3];
   logic [2:0] bdir_w  [3];
   logic [7:0] bval_w  [3];
   logic       found_w [3];

   logic       rd_req_m, busy_m, done_m, found_m;
   logic [7:0] rdx_m, bval_m;
   logic [6:0] rdy_m;
   logic [2:0] bdir_m;

   rd_t        exp_rd[$];
   res_t       exp_res[$];
   logic [7:0] vals_q[$];

   int cyc = 0;
   int n_pass = 0;
   int n_total = 0;
   int wait_n = 0;
   int wcnt = 0;
   logic req_prev = 1'b0;
   logic ack_prev = 1'b0;

   ant_sense_scan u_wrap3 (
      .Clk(Clk), .Reset_n(Reset_n), .start(start_w[0]), .X(X), .Y(Y), .dir(dir),
      .rd_req(rdreq_w[0]), .rd_X(rdx_w[0]), .rd_Y(rdy_w[0]), .rd_ack(ack_w[0]),
      .rd_data(rd_data_m), .busy(busy_w[0]), .done(done_w[0]),
      .best_dir(bdir_w[0]), .best_val(bval_w[0]), .found(found_w[0]));

   ant_sense_scan #(.WRAP(0)) u_clamp3 (
      .Clk(Clk), .Reset_n(Reset_n), .start(start_w[1]), .X(X), .Y(Y), .dir(dir),
      .rd_req(rdreq_w[1]), .rd_X(rdx_w[1]), .rd_Y(rdy_w[1]), .rd_ack(ack_w[1]),
      .rd_data(rd_data_m), .busy(busy_w[1]), .done(done_w[1]),
      .best_dir(bdir_w[1]), .best_val(bval_w[1]), .found(found_w[1]));

   ant_sense_scan #(.FAN(5)) u_wrap5 (
      .Clk(Clk), .Reset_n(Reset_n), .start(start_w[2]), .X(X), .Y(Y), .dir(dir),
      .rd_req(rdreq_w[2]), .rd_X(rdx_w[2]), .rd_Y(rdy_w[2]), .rd_ack(ack_w[2]),
      .rd_data(rd_data_m), .busy(busy_w[2]), .done(done_w[2]),
      .best_dir(bdir_w[2]), .best_val(bval_w[2]), .found(found_w[2]));

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         start_w[i] = start && (sel == 2'(i));
         ack_w[i]   = (rd_ack_m && (sel == 2'(i))) || ack_force;
      end
   end

   assign rd_req_m = rdreq_w[sel];
   assign rdx_m    = rdx_w[sel];
   assign rdy_m    = rdy_w[sel];
   assign busy_m   = busy_w[sel];
   assign done_m   = done_w[sel];
   assign bdir_m   = bdir_w[sel];
   assign bval_m   = bval_w[sel];
   assign found_m  = found_w[sel];

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   always @(posedge Clk) cyc <= cyc + 1;

   // One negedge: drive the grid response, then score reads and results.
   task automatic tick();
      logic consumed;
      logic ack_now;
      rd_t  e;
      res_t r;
      @(negedge Clk);
      consumed = req_prev && ack_prev;
      if (consumed && (vals_q.size() > 0)) vals_q.delete(0);
      if (!rd_req_m || consumed || !req_prev) wcnt = 0;
      else wcnt++;
      rd_ack_m  = rd_req_m && (wcnt >= wait_n);
      rd_data_m = (vals_q.size() > 0) ? vals_q[0] : 8'hEE;
      ack_now   = rd_ack_m || ack_force;
      req_prev  = rd_req_m && Reset_n;
      ack_prev  = ack_now && Reset_n;
      if (Reset_n) begin
         if (rd_req_m && (exp_rd.size() == 0)) begin
            n_total++;
            $display("FAIL unexpected_read cyc=%0d got (%0d,%0d) required no request", cyc, rdx_m, rdy_m);
         end else if (rd_req_m && ack_now) begin
            e = exp_rd.pop_front();
            n_total++;
            if ({rdx_m, rdy_m} !== {e.x, e.y})
               $display("FAIL read_addr cyc=%0d got (%0d,%0d) required (%0d,%0d)", cyc, rdx_m, rdy_m, e.x, e.y);
            else n_pass++;
         end
         if (done_m && (exp_res.size() == 0)) begin
            n_total++;
            $display("FAIL unexpected_done cyc=%0d", cyc);
         end else if (done_m) begin
            r = exp_res.pop_front();
            n_total++;
            if ({bdir_m, bval_m, found_m} !== {r.d, r.v, r.f})
               $display("FAIL result got dir=%0d val=%0d found=%0d required dir=%0d val=%0d found=%0d",
                        bdir_m, bval_m, found_m, r.d, r.v, r.f);
            else n_pass++;
            n_total++;
            if (cyc !== r.c) $display("FAIL done_cycle got %0d required %0d", cyc, r.c);
            else n_pass++;
         end
      end
   endtask

   function automatic void push_rd(input int x, input int y);
      rd_t e;
      e.x = 8'(x);
      e.y = 7'(y);
      exp_rd.push_back(e);
   endfunction

   function automatic void push_res(input int d, input int v, input int f, input int c);
      res_t r;
      r.d = 3'(d);
      r.v = 8'(v);
      r.f = 1'(f);
      r.c = c;
      exp_res.push_back(r);
   endfunction

   task automatic go(input int x, input int y, input int d, output int k);
      X     = 8'(x);
      Y     = 7'(y);
      dir   = 3'(d);
      start = 1'b1;
      k     = cyc + 1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int i;
      for (i = 0; (i < budget) && ((exp_res.size() > 0) || busy_m); i++) tick();
      n_total++;
      if ((exp_res.size() > 0) || busy_m)
         $display("FAIL timeout pending_results=%0d busy=%0d required 0/0", exp_res.size(), busy_m);
      else n_pass++;
      n_total++;
      if (exp_rd.size() != 0) $display("FAIL missing_reads got %0d pending required 0", exp_rd.size());
      else n_pass++;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         n_total++;
         if ({busy_w[i], done_w[i], rdreq_w[i], rdx_w[i], rdy_w[i], bdir_w[i], bval_w[i], found_w[i]} !== '0)
            $display("FAIL reset_outputs dut=%0d got nonzero required all 0", i);
         else n_pass++;
      end
      Reset_n = 1'b1;
      tick();
      tick();
      n_total++;
      if ({busy_m, done_m, rd_req_m, found_m} !== 4'b0)
         $display("FAIL idle_after_reset got %b required 0000", {busy_m, done_m, rd_req_m, found_m});
      else n_pass++;
   endtask

   task automatic test_basic();
      int k;
      sel = 2'd0; wait_n = 0;
      push_rd(10, 9); push_rd(9, 9); push_rd(11, 9);
      vals_q = '{8'd9, 8'd5, 8'd7};
      go(10, 10, 0, k);
      push_res(0, 9, 1, k + 3);
      n_total++;
      if (busy_m !== 1'b1) $display("FAIL busy_first_probe got %0d required 1", busy_m);
      else n_pass++;
      wait_idle(20);
   endtask

   task automatic test_ties();
      int k;
      sel = 2'd0; wait_n = 0;
      push_rd(11, 11); push_rd(11, 10); push_rd(10, 11);
      vals_q = '{8'd4, 8'd4, 8'd4};
      go(10, 10, 3, k);
      push_res(3, 4, 1, k + 3);
      wait_idle(20);
      repeat (3) tick();
      n_total++;
      if ({bdir_m, bval_m, found_m} !== {3'd3, 8'd4, 1'b1})
         $display("FAIL result_hold got dir=%0d val=%0d found=%0d required 3/4/1", bdir_m, bval_m, found_m);
      else n_pass++;
   endtask

   task automatic test_wrap();
      int k;
      sel = 2'd0; wait_n = 0;
      push_rd(159, 119); push_rd(159, 0); push_rd(0, 119);
      vals_q = '{8'd3, 8'd8, 8'd8};
      go(0, 0, 7, k);
      push_res(6, 8, 1, k + 3);
      wait_idle(20);
   endtask

   task automatic test_clamp();
      int k;
      sel = 2'd1; wait_n = 0; ack_force = 1'b1;
      go(0, 0, 7, k);
      push_res(7, 0, 0, k + 3);
      wait_idle(20);
      push_rd(159, 118); push_rd(158, 118);
      vals_q = '{8'd2, 8'd6};
      go(159, 119, 0, k);
      push_res(7, 6, 1, k + 3);
      wait_idle(20);
      ack_force = 1'b0;
   endtask

   task automatic test_fan5_slow();
      int k;
      logic preq, pack;
      logic [7:0] px;
      logic [6:0] py;
      sel = 2'd2; wait_n = 3;
      push_rd(51, 50); push_rd(51, 49); push_rd(51, 51); push_rd(50, 49); push_rd(50, 51);
      vals_q = '{8'd1, 8'd2, 8'd3, 8'd20, 8'd0};
      go(50, 50, 2, k);
      push_res(0, 20, 1, k + 20);
      preq = rd_req_m; pack = rd_ack_m; px = rdx_m; py = rdy_m;
      for (int i = 0; (i < 40) && (exp_res.size() > 0); i++) begin
         tick();
         if (preq && !pack && rd_req_m) begin
            n_total++;
            if ({rdx_m, rdy_m} !== {px, py})
               $display("FAIL addr_stable got (%0d,%0d) required (%0d,%0d)", rdx_m, rdy_m, px, py);
            else n_pass++;
         end
         preq = rd_req_m; pack = rd_ack_m; px = rdx_m; py = rdy_m;
      end
      wait_idle(10);
      wait_n = 0;
   endtask

   task automatic test_reset_mid_scan();
      int k;
      sel = 2'd0; wait_n = 3;
      push_rd(10, 9);
      vals_q = '{8'd5};
      go(10, 10, 0, k);
      tick();
      tick();
      n_total++;
      if ((rd_req_m !== 1'b1) || (rd_ack_m !== 1'b0))
         $display("FAIL waiting_on_ack got req=%0d ack=%0d required 1/0", rd_req_m, rd_ack_m);
      else n_pass++;
      #1 Reset_n = 1'b0;
      #1;
      n_total++;
      if ({busy_m, done_m, rd_req_m, rdx_m, rdy_m, bdir_m, bval_m, found_m} !== '0)
         $display("FAIL reset_mid_scan got busy=%0d req=%0d x=%0d y=%0d required all 0",
                  busy_m, rd_req_m, rdx_m, rdy_m);
      else n_pass++;
      exp_rd.delete();
      vals_q.delete();
      tick();
      Reset_n = 1'b1;
      tick();
      wait_n = 1;
      push_rd(20, 31); push_rd(21, 31); push_rd(19, 31);
      vals_q = '{8'd1, 8'd1, 8'd2};
      go(20, 30, 4, k);
      push_res(5, 2, 1, k + 6);
      tick();
      tick();
      X = 8'd100; Y = 7'd100; dir = 3'd0; start = 1'b1;
      tick();
      start = 1'b0;
      wait_idle(30);
      wait_n = 0;
   endtask

   task automatic test_back_to_back();
      int k;
      sel = 2'd0; wait_n = 0;
      push_rd(69, 60); push_rd(69, 61); push_rd(69, 59);
      push_rd(30, 41); push_rd(31, 41); push_rd(29, 41);
      vals_q = '{8'd3, 8'd9, 8'd9, 8'd0, 8'd0, 8'd1};
      X = 8'd70; Y = 7'd60; dir = 3'd6; start = 1'b1;
      k = cyc + 1;
      push_res(5, 9, 1, k + 3);
      push_res(5, 1, 1, k + 8);
      tick();
      X = 8'd30; Y = 7'd40; dir = 3'd4;
      for (int i = 0; (i < 20) && (cyc < k + 5); i++) begin
         tick();
         if (cyc == k + 4) begin
            n_total++;
            if (busy_m !== 1'b0) $display("FAIL busy_after_done got %0d required 0", busy_m);
            else n_pass++;
         end
      end
      start = 1'b0;
      wait_idle(20);
   endtask

   initial begin
      Reset_n = 1'b0; start = 1'b0; X = '0; Y = '0; dir = '0;
      rd_ack_m = 1'b0; rd_data_m = '0; ack_force = 1'b0; sel = 2'd0;
      tick();
      tick();
      test_reset();
      test_basic();
      test_ties();
      test_wrap();
      test_clamp();
      test_fan5_slow();
      test_reset_mid_scan();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
